// File: rtl/mmu_pkg.sv
// Shared types and default sizes for the translation request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: scheduler FSM state encoding, page-offset width, default widths.
package mmu_pkg;

    // 4 KiB pages: the low 12 address bits pass through translation untouched.
    localparam int PAGE_OFFSET_W = 12;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_ADDR_WIDTH   = 48;
    localparam int DEF_VPN_WIDTH    = 24;
    localparam int DEF_PPN_WIDTH    = 24;
    localparam int DEF_WALK_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_CHECK     = 3'd2,
        ST_WALK_REQ  = 3'd3,
        ST_WALK_WAIT = 3'd4,
        ST_FILL      = 3'd5,
        ST_RESP      = 3'd6
    } sched_state_e;

endpackage

// File: rtl/tlb_req_sched_rr_arbiter.sv
// Round-robin arbiter: picks one requester starting the search at a rotating pointer.
// Latency: grant is combinational from req_i; the pointer moves on the advance edge.
// Backpressure: none; a grant is only consumed when advance_i is high.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req_i       request vector
//   advance_i   the current grant is taken; pointer moves past the winner
//   gnt_o       one-hot grant (zero when no request)
//   idx_o       index of the granted requester
//   any_o       at least one request present
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cidx;

    // Walk the requesters in order ptr, ptr+1, ... wrapping at NUM_REQ; the
    // first one found wins. cand carries an extra bit so the wrap compare
    // works for non-power-of-two NUM_REQ.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        cidx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            cidx = cand[IDX_W-1:0];
            if (!any_o && req_i[cidx]) begin
                any_o       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

    // The winner becomes the lowest priority for the next round.
    always_comb begin
        if (idx_o == IDX_W'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance_i && any_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tlb_req_sched.sv
// Translation request scheduler: arbitrates requesters, looks up the TLB, walks on miss, refills, responds.
// Latency: hit response 3 cycles after accept; miss adds walker handshake and response waits.
// Backpressure: one translation in flight; req_ready only in IDLE; walk request held until walker ready; no response backpressure.
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   req_valid/req_vaddr/req_ready   per-requester request, packed vaddrs, one-hot accept
//   rsp_valid/rsp_id/rsp_paddr/rsp_fault   one-cycle translation result
//   tlb_lookup_valid/tlb_lookup_vaddr, tlb_hit/tlb_ppn   TLB probe and its next-cycle answer
//   walk_req_valid/walk_req_vpn/walk_req_ready   page-walk request handshake
//   walk_rsp_valid/walk_rsp_ppn/walk_rsp_fault   page-walk result
//   tlb_fill_valid/tlb_fill_vpn/tlb_fill_ppn     TLB refill strobe after a good walk
module tlb_req_sched
    import mmu_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int VPN_WIDTH    = DEF_VPN_WIDTH,
    parameter int PPN_WIDTH    = DEF_PPN_WIDTH,
    parameter int WALK_TIMEOUT = DEF_WALK_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_vaddr,
    output logic [NUM_REQ-1:0]            req_ready,

    output logic                          rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
    output logic [ADDR_WIDTH-1:0]         rsp_paddr,
    output logic                          rsp_fault,

    output logic                          tlb_lookup_valid,
    output logic [ADDR_WIDTH-1:0]         tlb_lookup_vaddr,
    input  logic                          tlb_hit,
    input  logic [PPN_WIDTH-1:0]          tlb_ppn,

    output logic                          walk_req_valid,
    output logic [VPN_WIDTH-1:0]          walk_req_vpn,
    input  logic                          walk_req_ready,
    input  logic                          walk_rsp_valid,
    input  logic [PPN_WIDTH-1:0]          walk_rsp_ppn,
    input  logic                          walk_rsp_fault,

    output logic                          tlb_fill_valid,
    output logic [VPN_WIDTH-1:0]          tlb_fill_vpn,
    output logic [PPN_WIDTH-1:0]          tlb_fill_ppn
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int TO_W = (WALK_TIMEOUT > 0) ? $clog2(WALK_TIMEOUT + 1) : 1;
    localparam int PA_W = PPN_WIDTH + PAGE_OFFSET_W;

    sched_state_e            state_q;
    logic                    run_q;
    logic [ADDR_WIDTH-1:0]   vaddr_q;
    logic [ID_W-1:0]         id_q;
    logic [PPN_WIDTH-1:0]    ppn_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    fault_q;
    logic [TO_W-1:0]         to_cnt_q;
    logic                    lookup_vld_q;
    logic                    walk_vld_q;
    logic                    fill_vld_q;
    logic                    rsp_vld_q;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [ID_W-1:0]         arb_idx;
    logic                    arb_any;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   sel_vaddr;
    logic [PPN_WIDTH-1:0]    ppn_src;
    logic [PA_W-1:0]         pa_full;
    logic [ADDR_WIDTH-1:0]   pa_fmt;

    // ------------------------------------------------------------------
    // Arbitration and accept
    // ------------------------------------------------------------------
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req_valid),
        .advance_i (accept),
        .gnt_o     (arb_gnt),
        .idx_o     (arb_idx),
        .any_o     (arb_any)
    );

    // run_q is a registered "out of reset" flag: it keeps req_ready low while
    // reset is held even though the FSM already sits in IDLE, without putting
    // rst_n into the combinational path.
    assign accept    = run_q && (state_q == ST_IDLE) && arb_any;
    assign req_ready = accept ? arb_gnt : '0;

    // One-hot mux of the winning requester's address slice.
    always_comb begin
        sel_vaddr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                sel_vaddr = req_vaddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Physical address formation
    // ------------------------------------------------------------------
    // CHECK uses the TLB's PPN directly; FILL uses the PPN latched from the walker.
    assign ppn_src = (state_q == ST_CHECK) ? tlb_ppn : ppn_q;
    assign pa_full = {ppn_src, vaddr_q[PAGE_OFFSET_W-1:0]};

    generate
        if (PA_W >= ADDR_WIDTH) begin : g_pa_trunc
            assign pa_fmt = pa_full[ADDR_WIDTH-1:0];
        end else begin : g_pa_zext
            assign pa_fmt = {{(ADDR_WIDTH-PA_W){1'b0}}, pa_full};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scheduler FSM with registered strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            vaddr_q      <= '0;
            id_q         <= '0;
            ppn_q        <= '0;
            paddr_q      <= '0;
            fault_q      <= 1'b0;
            to_cnt_q     <= '0;
            lookup_vld_q <= 1'b0;
            walk_vld_q   <= 1'b0;
            fill_vld_q   <= 1'b0;
            rsp_vld_q    <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            // Single-cycle strobes default low; states below raise them for
            // exactly the cycle that follows the transition.
            lookup_vld_q <= 1'b0;
            fill_vld_q   <= 1'b0;
            rsp_vld_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        vaddr_q      <= sel_vaddr;
                        id_q         <= arb_idx;
                        lookup_vld_q <= 1'b1;
                        state_q      <= ST_LOOKUP;
                    end
                end

                ST_LOOKUP: begin
                    state_q <= ST_CHECK;
                end

                ST_CHECK: begin
                    if (tlb_hit) begin
                        paddr_q   <= pa_fmt;
                        fault_q   <= 1'b0;
                        rsp_vld_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        walk_vld_q <= 1'b1;
                        state_q    <= ST_WALK_REQ;
                    end
                end

                ST_WALK_REQ: begin
                    if (walk_req_ready) begin
                        walk_vld_q <= 1'b0;
                        state_q    <= ST_WALK_WAIT;
                    end
                end

                ST_WALK_WAIT: begin
                    // A response arriving in the timeout cycle itself still wins.
                    if (walk_rsp_valid) begin
                        to_cnt_q <= '0;
                        if (walk_rsp_fault) begin
                            paddr_q   <= '0;
                            fault_q   <= 1'b1;
                            rsp_vld_q <= 1'b1;
                            state_q   <= ST_RESP;
                        end else begin
                            ppn_q      <= walk_rsp_ppn;
                            fill_vld_q <= 1'b1;
                            state_q    <= ST_FILL;
                        end
                    end else if (to_cnt_q == TO_W'(WALK_TIMEOUT)) begin
                        // Walker gave up on us; report a fault. Any late
                        // response lands outside WALK_WAIT and is dropped.
                        to_cnt_q  <= '0;
                        paddr_q   <= '0;
                        fault_q   <= 1'b1;
                        rsp_vld_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                ST_FILL: begin
                    paddr_q   <= pa_fmt;
                    fault_q   <= 1'b0;
                    rsp_vld_q <= 1'b1;
                    state_q   <= ST_RESP;
                end

                ST_RESP: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: strobes from registers, data from the latched translation
    // ------------------------------------------------------------------
    assign tlb_lookup_valid = lookup_vld_q;
    assign tlb_lookup_vaddr = vaddr_q;

    assign walk_req_valid   = walk_vld_q;
    assign walk_req_vpn     = vaddr_q[VPN_WIDTH+PAGE_OFFSET_W-1:PAGE_OFFSET_W];

    assign tlb_fill_valid   = fill_vld_q;
    assign tlb_fill_vpn     = vaddr_q[VPN_WIDTH+PAGE_OFFSET_W-1:PAGE_OFFSET_W];
    assign tlb_fill_ppn     = ppn_q;

    assign rsp_valid        = rsp_vld_q;
    assign rsp_id           = id_q;
    assign rsp_paddr        = paddr_q;
    assign rsp_fault        = fault_q;

endmodule

// File: tb/tb_tlb_req_sched.sv
// Directed bench for tlb_req_sched: hit, miss/fill, fault, timeout, reset mid-walk, fairness.
// Latency: measured in cycles from the accept cycle / walker handshake cycle.
// Backpressure: requesters hold valid until their req_ready is seen.
module tb_tlb_req_sched;

    localparam int NR = 4;
    localparam int AW = 48;
    localparam int VW = 24;
    localparam int PW = 24;
    localparam int WT = 255;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_vaddr;
    logic [NR-1:0]     req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [AW-1:0]     rsp_paddr;
    logic              rsp_fault;
    logic              tlb_lookup_valid;
    logic [AW-1:0]     tlb_lookup_vaddr;
    logic              tlb_hit;
    logic [PW-1:0]     tlb_ppn;
    logic              walk_req_valid;
    logic [VW-1:0]     walk_req_vpn;
    logic              walk_req_ready;
    logic              walk_rsp_valid;
    logic [PW-1:0]     walk_rsp_ppn;
    logic              walk_rsp_fault;
    logic              tlb_fill_valid;
    logic [VW-1:0]     tlb_fill_vpn;
    logic [PW-1:0]     tlb_fill_ppn;

    always #5 clk = ~clk;

    tlb_req_sched #(
        .NUM_REQ      (NR),
        .ADDR_WIDTH   (AW),
        .VPN_WIDTH    (VW),
        .PPN_WIDTH    (PW),
        .WALK_TIMEOUT (WT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_vaddr        (req_vaddr),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .rsp_paddr        (rsp_paddr),
        .rsp_fault        (rsp_fault),
        .tlb_lookup_valid (tlb_lookup_valid),
        .tlb_lookup_vaddr (tlb_lookup_vaddr),
        .tlb_hit          (tlb_hit),
        .tlb_ppn          (tlb_ppn),
        .walk_req_valid   (walk_req_valid),
        .walk_req_vpn     (walk_req_vpn),
        .walk_req_ready   (walk_req_ready),
        .walk_rsp_valid   (walk_rsp_valid),
        .walk_rsp_ppn     (walk_rsp_ppn),
        .walk_rsp_fault   (walk_rsp_fault),
        .tlb_fill_valid   (tlb_fill_valid),
        .tlb_fill_vpn     (tlb_fill_vpn),
        .tlb_fill_ppn     (tlb_fill_ppn)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- cycle counter and output monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0] last_gnt = '0;
    int            acc_cyc = 0;
    int            gq[$];
    int            rq[$];
    int            onehot_bad = 0;
    int            rsp_cnt = 0;
    int            rsp_cyc = 0;
    logic [1:0]    rsp_id_s;
    logic [AW-1:0] rsp_paddr_s;
    logic          rsp_fault_s;
    int            lookup_cnt = 0;
    logic [AW-1:0] lookup_vaddr_s;
    int            fill_cnt = 0;
    logic [VW-1:0] fill_vpn_s;
    logic [PW-1:0] fill_ppn_s;
    int            wreq_hi = 0;
    int            wreq_rise = 0;
    logic          wreq_prev = 1'b0;
    logic [VW-1:0] wreq_vpn_s;
    int            hs_cyc = 0;

    always @(negedge clk) begin
        last_gnt = req_ready;
        if (rst_n) begin
            if (req_ready != '0) begin
                acc_cyc = cyc;
                for (int k = 0; k < NR; k++) if (req_ready[k]) gq.push_back(k);
                if ($countones(req_ready) != 1) onehot_bad++;
            end
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_cyc     = cyc;
                rsp_id_s    = rsp_id;
                rsp_paddr_s = rsp_paddr;
                rsp_fault_s = rsp_fault;
                rq.push_back(int'(rsp_id));
            end
            if (tlb_lookup_valid) begin
                lookup_cnt++;
                lookup_vaddr_s = tlb_lookup_vaddr;
            end
            if (tlb_fill_valid) begin
                fill_cnt++;
                fill_vpn_s = tlb_fill_vpn;
                fill_ppn_s = tlb_fill_ppn;
            end
            if (walk_req_valid) begin
                wreq_hi++;
                if (!wreq_prev) begin
                    wreq_rise++;
                    wreq_vpn_s = walk_req_vpn;
                end
                if (walk_req_ready) hs_cyc = cyc;
            end
        end
        wreq_prev = walk_req_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_vaddr(input int k, input logic [AW-1:0] v);
        req_vaddr[k*AW +: AW] = v;
    endtask

    // Advance one cycle; requesters that were just accepted drop valid.
    task automatic step();
        @(posedge clk);
        #2;
        req_valid = req_valid & ~last_gnt;
    endtask

    task automatic wait_rsp(input int base, input int budget, input string tag);
        int n = 0;
        while (rsp_cnt == base && n < budget) begin
            step();
            n++;
        end
        if (rsp_cnt == base) chk({tag, "_rsp_timeout"}, 64'd0, 64'd1);
    endtask

    // Walker: ready in cycle w0+rdy_dly (w0 = first walk_req_valid cycle),
    // response in cycle h+rsp_dly (h = handshake cycle) when respond is set.
    task automatic walk_seq(input int rdy_dly, input int rsp_dly, input bit respond,
                            input bit fault, input logic [PW-1:0] ppn);
        int base = wreq_rise;
        int n = 0;
        while (wreq_rise == base && n < 20) begin
            step();
            n++;
        end
        if (wreq_rise == base) begin
            chk("walk_req_timeout", 64'd0, 64'd1);
            return;
        end
        repeat (rdy_dly - 1) step();
        walk_req_ready = 1'b1;
        step();
        walk_req_ready = 1'b0;
        if (respond) begin
            repeat (rsp_dly - 1) step();
            walk_rsp_valid = 1'b1;
            walk_rsp_fault = fault;
            walk_rsp_ppn   = ppn;
            step();
            walk_rsp_valid = 1'b0;
            walk_rsp_fault = 1'b0;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_req_ready"},  64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"},  64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_id"},     64'(rsp_id), 64'd0);
        chk({tag, "_rsp_paddr"},  64'(rsp_paddr), 64'd0);
        chk({tag, "_rsp_fault"},  64'(rsp_fault), 64'd0);
        chk({tag, "_lookup"},     64'(tlb_lookup_valid), 64'd0);
        chk({tag, "_walk_req"},   64'(walk_req_valid), 64'd0);
        chk({tag, "_walk_vpn"},   64'(walk_req_vpn), 64'd0);
        chk({tag, "_fill"},       64'(tlb_fill_valid), 64'd0);
        chk({tag, "_fill_ppn"},   64'(tlb_fill_ppn), 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int b;
        int fc;
        int lc;
        int wh;
        int g0;
        int r0;
        int n;

        rst_n          = 1'b1;
        req_valid      = '0;
        req_vaddr      = '0;
        tlb_hit        = 1'b0;
        tlb_ppn        = '0;
        walk_req_ready = 1'b0;
        walk_rsp_valid = 1'b0;
        walk_rsp_ppn   = '0;
        walk_rsp_fault = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state, with requests pending so req_ready gating is exercised.
        req_valid = 4'hF;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("rst");
        req_valid = '0;
        rst_n = 1'b1;
        repeat (3) step();

        // ---- hit path: req0 ----
        tlb_hit = 1'b1;
        tlb_ppn = 24'h0ABCDE;
        set_vaddr(0, 48'h0000_1234_5678);
        b = rsp_cnt; lc = lookup_cnt; g0 = gq.size();
        req_valid = 4'b0001;
        #1;
        chk("hit_req_ready", 64'(req_ready), 64'h1);
        wait_rsp(b, 20, "hit");
        chk("hit_latency",   64'(rsp_cyc - acc_cyc), 64'd3);
        chk("hit_id",        64'(rsp_id_s), 64'd0);
        chk("hit_paddr",     64'(rsp_paddr_s), 64'h0000_ABCD_E678);
        chk("hit_fault",     64'(rsp_fault_s), 64'd0);
        chk("hit_lookups",   64'(lookup_cnt - lc), 64'd1);
        chk("hit_lookup_va", 64'(lookup_vaddr_s), 64'h0000_1234_5678);
        chk("hit_grants",    64'(gq.size() - g0), 64'd1);

        // ---- miss path: req2, ready after 2, response after 5 ----
        tlb_hit = 1'b0;
        set_vaddr(2, 48'h0000_9876_5432);
        b = rsp_cnt; fc = fill_cnt; wh = wreq_hi;
        req_valid = 4'b0100;
        walk_seq(2, 5, 1'b1, 1'b0, 24'h000042);
        wait_rsp(b, 20, "miss");
        chk("miss_walk_vpn",  64'(wreq_vpn_s), 64'h098765);
        chk("miss_walk_hold", 64'(wreq_hi - wh), 64'd3);
        chk("miss_fills",     64'(fill_cnt - fc), 64'd1);
        chk("miss_fill_vpn",  64'(fill_vpn_s), 64'h098765);
        chk("miss_fill_ppn",  64'(fill_ppn_s), 64'h000042);
        chk("miss_latency",   64'(rsp_cyc - acc_cyc), 64'd12);
        chk("miss_id",        64'(rsp_id_s), 64'd2);
        chk("miss_paddr",     64'(rsp_paddr_s), 64'h0000_0004_2432);
        chk("miss_fault",     64'(rsp_fault_s), 64'd0);

        // ---- walker fault: req3 ----
        set_vaddr(3, 48'h0000_0000_3ABC);
        b = rsp_cnt; fc = fill_cnt;
        req_valid = 4'b1000;
        walk_seq(1, 2, 1'b1, 1'b1, 24'h000077);
        wait_rsp(b, 20, "flt");
        chk("flt_fault",   64'(rsp_fault_s), 64'd1);
        chk("flt_paddr",   64'(rsp_paddr_s), 64'd0);
        chk("flt_id",      64'(rsp_id_s), 64'd3);
        chk("flt_no_fill", 64'(fill_cnt - fc), 64'd0);
        chk("flt_latency", 64'(rsp_cyc - acc_cyc), 64'd7);

        // ---- walk timeout: req0, walker never answers ----
        set_vaddr(0, 48'h0000_0055_5123);
        b = rsp_cnt; fc = fill_cnt;
        req_valid = 4'b0001;
        walk_seq(1, 0, 1'b0, 1'b0, '0);
        wait_rsp(b, WT + 40, "tmo");
        chk("tmo_latency", 64'(rsp_cyc - hs_cyc), 64'(WT + 2));
        chk("tmo_fault",   64'(rsp_fault_s), 64'd1);
        chk("tmo_paddr",   64'(rsp_paddr_s), 64'd0);
        chk("tmo_no_fill", 64'(fill_cnt - fc), 64'd0);
        // A late walker answer must be ignored.
        b = rsp_cnt;
        step();
        walk_rsp_valid = 1'b1;
        walk_rsp_ppn   = 24'h000099;
        step();
        walk_rsp_valid = 1'b0;
        repeat (6) step();
        chk("stray_no_rsp",  64'(rsp_cnt - b), 64'd0);
        chk("stray_no_fill", 64'(fill_cnt - fc), 64'd0);

        // ---- reset while in WALK_WAIT: req1 ----
        set_vaddr(1, 48'h0000_0011_1222);
        set_vaddr(3, 48'h0000_0AAA_A9F0);
        b = rsp_cnt; fc = fill_cnt;
        req_valid = 4'b0010;
        walk_seq(1, 0, 1'b0, 1'b0, '0);
        repeat (3) step();
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rstw");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tlb_hit = 1'b1;
        tlb_ppn = 24'h000123;
        g0 = gq.size(); r0 = rq.size();
        wait_rsp(b, 20, "rstw_a");
        wait_rsp(b + 1, 20, "rstw_b");
        repeat (4) step();
        chk("rstw_rsp_count", 64'(rsp_cnt - b), 64'd2);
        chk("rstw_no_fill",   64'(fill_cnt - fc), 64'd0);
        chk("rstw_grants",    64'(gq.size() - g0), 64'd2);
        if (gq.size() >= g0 + 2) begin
            chk("rstw_grant0", 64'(gq[g0]), 64'd1);
            chk("rstw_grant1", 64'(gq[g0+1]), 64'd3);
        end
        if (rq.size() >= r0 + 2) begin
            chk("rstw_rsp_id0", 64'(rq[r0]), 64'd1);
            chk("rstw_rsp_id1", 64'(rq[r0+1]), 64'd3);
        end
        chk("rstw_paddr", 64'(rsp_paddr_s), 64'h0000_0012_39F0);

        // ---- fairness: all requesters continuously valid, from reset ----
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < NR; k++) set_vaddr(k, 48'(k * 4096 + 16));
        g0 = gq.size(); r0 = rq.size();
        req_valid = 4'hF;
        n = 0;
        while (gq.size() < g0 + 5 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        req_valid = '0;
        if (gq.size() < g0 + 5) chk("fair_grant_timeout", 64'd0, 64'd1);
        n = 0;
        while (rq.size() < r0 + 5 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (rq.size() < r0 + 5) chk("fair_rsp_timeout", 64'd0, 64'd1);
        repeat (8) step();
        chk("fair_grants", 64'(gq.size() - g0), 64'd5);
        if (gq.size() >= g0 + 5 && rq.size() >= r0 + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("fair_grant%0d", i), 64'(gq[g0+i]), 64'(i % NR));
                chk($sformatf("fair_rsp_id%0d", i), 64'(rq[r0+i]), 64'(i % NR));
            end
        end

        chk("grant_onehot", 64'(onehot_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
